// File: rtl/bus_ep_pkg.sv
// bus_ep_pkg: shared IDs, error-bit indices and destination-field helper for the bus endpoint
package bus_ep_pkg;
  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;
  localparam int TX_OVF = 0;
  localparam int TX_UNF = 1;
  localparam int RX_OVF = 2;
  localparam int MISADDR = 3;
  localparam int MAX_W = 64;
  function automatic logic [ID_W-1:0] get_dest(input logic [MAX_W-1:0] pkt, input int unsigned pckg_sz);
    return pkt[pckg_sz-1 -: ID_W];
  endfunction
endpackage

// File: rtl/bus_dev_endpoint_fifo.sv
// ep_fifo: first-word-fall-through FIFO with occupancy count and overflow/underflow pulses
module ep_fifo #(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr,
  input  logic                         rd,
  input  logic [width-1:0]             din,
  output logic [width-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(depth+1)-1:0]   count,
  output logic                         ovf,
  output logic                         unf
);
  localparam int AW = $clog2(depth);
  localparam int CW = $clog2(depth+1);
  logic [width-1:0] mem [depth];
  logic [AW-1:0] wp, rp;
  logic re, we;
  assign empty = count == '0;
  assign full = count == CW'(depth);
  assign re = rd && !empty;
  // a read frees the slot the write needs, so write-while-full succeeds when paired with a read
  assign we = wr && (!full || re);
  assign ovf = wr && !we;
  assign unf = rd && empty;
  assign dout = empty ? '0 : mem[rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (we) mem[wp] <= din;
      if (we) wp <= wp + 1'b1;
      if (re) rp <= rp + 1'b1;
      count <= count + CW'(we) - CW'(re);
    end
  end
endmodule

// File: rtl/bus_dev_endpoint.sv
// bus_dev_endpoint: device-side bus terminal with TX/RX FIFOs and sticky error flags
// optional destination filter enabled by defining BUS_EP_ADDR_CHECK_EN
module bus_dev_endpoint
  import bus_ep_pkg::*;
#(
  parameter int pckg_sz = 16,
  parameter int depth = 8,
  parameter logic [ID_W-1:0] drv_id = 8'd0,
  parameter logic [ID_W-1:0] broadcast = BCAST_ID
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         pndng,
  output logic [pckg_sz-1:0]           D_pop,
  input  logic                         pop,
  input  logic                         push,
  input  logic [pckg_sz-1:0]           D_push,
  input  logic                         tx_wr,
  input  logic [pckg_sz-1:0]           tx_data,
  output logic                         tx_full,
  input  logic                         rx_rd,
  output logic [pckg_sz-1:0]           rx_data,
  output logic                         rx_empty,
  output logic [$clog2(depth+1)-1:0]   rx_count,
  output logic [3:0]                   err_flags
);
  logic tx_empty, tx_ovf, tx_unf, rx_full, rx_ovf, rx_unf, accept, misaddr;
  logic [$clog2(depth+1)-1:0] tx_count;
  logic unused;
`ifdef BUS_EP_ADDR_CHECK_EN
  logic [ID_W-1:0] dest;
  assign dest = get_dest(MAX_W'(D_push), pckg_sz);
  assign accept = dest == drv_id || dest == broadcast;
`else
  assign accept = 1'b1;
`endif
  assign misaddr = push && !accept;
  assign pndng = !tx_empty;
  assign unused = ^{tx_count, rx_full, rx_unf, drv_id, broadcast};
  ep_fifo #(.width(pckg_sz), .depth(depth)) u_tx (
    .clk(clk), .rst(reset), .wr(tx_wr), .rd(pop), .din(tx_data), .dout(D_pop),
    .full(tx_full), .empty(tx_empty), .count(tx_count), .ovf(tx_ovf), .unf(tx_unf)
  );
  // filtered pushes never reach the RX FIFO, so they cannot also raise rx_ovf
  ep_fifo #(.width(pckg_sz), .depth(depth)) u_rx (
    .clk(clk), .rst(reset), .wr(push && accept), .rd(rx_rd), .din(D_push), .dout(rx_data),
    .full(rx_full), .empty(rx_empty), .count(rx_count), .ovf(rx_ovf), .unf(rx_unf)
  );
  always_ff @(posedge clk) begin
    if (reset) err_flags <= '0;
    else begin
      err_flags[TX_OVF] <= err_flags[TX_OVF] | tx_ovf;
      err_flags[TX_UNF] <= err_flags[TX_UNF] | tx_unf;
      err_flags[RX_OVF] <= err_flags[RX_OVF] | rx_ovf;
      err_flags[MISADDR] <= err_flags[MISADDR] | misaddr;
    end
  end
endmodule

// File: tb/tb_bus_dev_endpoint.sv
// tb_bus_dev_endpoint: directed and randomized checks against a queue-based reference model
module tb_bus_dev_endpoint;
  logic clk = 0, reset = 1, pop = 0, push = 0, tx_wr = 0, rx_rd = 0;
  logic [15:0] D_push = 0, tx_data = 0;
  logic pndng, tx_full, rx_empty;
  logic [15:0] D_pop, rx_data;
  logic [3:0] rx_count, err_flags;
  int checks = 0, errors = 0;
  logic [15:0] txq[$], rxq[$];
  logic [3:0] em = 0;

  always #5 clk = ~clk;

  bus_dev_endpoint #(.pckg_sz(16), .depth(8), .drv_id(8'd3), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push),
    .D_push(D_push), .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full), .rx_rd(rx_rd),
    .rx_data(rx_data), .rx_empty(rx_empty), .rx_count(rx_count), .err_flags(err_flags)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic bit addr_ok(input logic [15:0] p);
`ifdef BUS_EP_ADDR_CHECK_EN
    return p[15:8] == 8'd3 || p[15:8] == 8'hFF;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model(input logic r, w, input logic [15:0] td, input logic p, ps, input logic [15:0] dp, input logic rr);
    bit pok, rok, st;
    if (r) begin
      txq.delete(); rxq.delete(); em = 0;
      return;
    end
    pok = p && txq.size() > 0;
    if (p && txq.size() == 0) em[1] = 1;
    if (w && !(txq.size() < 8 || pok)) em[0] = 1;
    if (pok) void'(txq.pop_front());
    if (w && (txq.size() < 8)) txq.push_back(td);
    st = ps && addr_ok(dp);
    if (ps && !st) em[3] = 1;
    rok = rr && rxq.size() > 0;
    if (st && rxq.size() == 8 && !rok) em[2] = 1;
    if (rok) void'(rxq.pop_front());
    if (st && rxq.size() < 8) rxq.push_back(dp);
  endtask

  task automatic cyc(input logic r, w, input logic [15:0] td, input logic p, ps, input logic [15:0] dp, input logic rr);
    reset = r; tx_wr = w; tx_data = td; pop = p; push = ps; D_push = dp; rx_rd = rr;
    @(posedge clk);
    #1;
    model(r, w, td, p, ps, dp, rr);
    chk("pndng", pndng, txq.size() > 0);
    chk("D_pop", D_pop, txq.size() > 0 ? txq[0] : 16'h0);
    chk("tx_full", tx_full, txq.size() == 8);
    chk("rx_empty", rx_empty, rxq.size() == 0);
    chk("rx_data", rx_data, rxq.size() > 0 ? rxq[0] : 16'h0);
    chk("rx_count", rx_count, rxq.size());
    chk("err_flags", err_flags, em);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [15:0] d;
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("reset_rx_empty", rx_empty, 1);
    // single write then pop
    cyc(0, 1, 16'h02AB, 0, 0, 0, 0);
    chk("first_dpop", D_pop, 16'h02AB);
    idle(); idle();
    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("popped_pndng", pndng, 0);
    // fill TX and overflow
    for (int i = 0; i < 8; i++) cyc(0, 1, 16'h0100 + 16'(i), 0, 0, 0, 0);
    cyc(0, 1, 16'h01FF, 0, 0, 0, 0);
    chk("tx_ovf_flag", err_flags, 4'b0001);
    chk("tx_full_set", tx_full, 1);
    // write+pop at full, then drain
    cyc(0, 1, 16'h0155, 1, 0, 0, 0);
    chk("wr_pop_full", tx_full, 1);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1, 0, 0, 0);
    chk("last_out", D_pop, 16'h0155);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("unf_flag", err_flags[1], 1);
    chk("unf_dpop", D_pop, 0);
    // pop+write while empty
    cyc(0, 1, 16'h0777, 1, 0, 0, 0);
    chk("wr_pop_empty", D_pop, 16'h0777);
    // address filter
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 16'h0311, 0);
    cyc(0, 0, 0, 0, 1, 16'hFF22, 0);
    cyc(0, 0, 0, 0, 1, 16'h0533, 0);
`ifdef BUS_EP_ADDR_CHECK_EN
    chk("filt_count", rx_count, 2);
    chk("filt_flag", err_flags[3], 1);
`else
    chk("nofilt_count", rx_count, 3);
    chk("nofilt_flag", err_flags[3], 0);
`endif
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("rx_second", rx_data, 16'hFF22);
    // RX fill, overflow, push+read at full
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 1, 16'h0300 + 16'(i), 0);
    chk("rx_full_cnt", rx_count, 8);
    chk("rx_ovf_flag", err_flags[2], 1);
    cyc(0, 0, 0, 0, 1, 16'hFFAA, 1);
    chk("rx_pr_full", rx_count, 8);
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 0, 0, 1);
    chk("rx_rd_empty_flags", err_flags, 4'b0100);
    // mid-operation reset
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 16'h0A00 + 16'(i), 0, i < 3, 16'h0300 + 16'(i), 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(1, 1, 16'h1234, 1, 1, 16'h0399, 1);
    chk("mid_pndng", pndng, 0);
    chk("mid_rx_empty", rx_empty, 1);
    chk("mid_rx_count", rx_count, 0);
    chk("mid_err", err_flags, 0);
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 2))
        0: d = {8'd3, 8'($urandom)};
        1: d = {8'hFF, 8'($urandom)};
        default: d = 16'($urandom);
      endcase
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 99) < 55, 16'($urandom),
          $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 55, d, $urandom_range(0, 99) < 45);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
